cpu_trace_capture: RTL and testbench

//  Consumer of the MultiCycle_CPU debug/observation port. On every instruction

---
 rtl/trace_pkg.sv | 29 ++
 rtl/trace_fifo.sv | 54 +++++
 rtl/cpu_trace_capture.sv | 126 ++++++++++++
 tb/tb_cpu_trace_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the CPU trace capture block: readout word states
// and the layout of one captured retirement record.
package trace_pkg;

  typedef enum logic [1:0] {
    W_PC    = 2'd0,
    W_INSTR = 2'd1,
    W_REG   = 2'd2,
    W_DATA  = 2'd3
  } word_state_t;

  localparam int REC_W      = 102;
  localparam int WBDATA_LSB = 0;
  localparam int WBREG_LSB  = 32;
  localparam int WBEN_BIT   = 37;
  localparam int INSTR_LSB  = 38;
  localparam int PC_LSB     = 70;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic        wb_en,
    input logic [4:0]  wb_reg,
    input logic [31:0] wb_data
  );
    return {pc, instr, wb_en, wb_reg, wb_data};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the trace capture block: combinational head read,
// a push while full is ignored even when a pop happens in the same cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [REC_W-1:0] i_wdata,
  input  logic             i_pop,
  output logic [REC_W-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; emptiness is carried entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Captures one record per CPU instruction retirement (PC, instruction, register
// writeback) and streams each record out as four 32-bit words on valid/ready.
module cpu_trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  PCWre,
  input  logic [31:0]           _Pc0,
  input  logic [31:0]           _instruction,
  input  logic                  RegWre,
  input  logic [4:0]            _thirdRg,
  input  logic [31:0]           _WBdata,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  word_state_t           r_state;
  word_state_t           w_state_nxt;
  logic                  r_pend_en;
  logic [4:0]            r_pend_reg;
  logic [31:0]           r_pend_data;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_wb_en;
  logic [4:0]            w_wb_reg;
  logic [31:0]           w_wb_data;
  logic [REC_W-1:0]      w_rec;
  logic [REC_W-1:0]      w_head;
  logic                  w_push_req;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic                  w_hs;
  logic                  w_pop;
  logic [31:0]           w_word;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A same-cycle register write takes priority over the pending latch, which
  // holds all-zero fields whenever no write is pending.
  assign w_wb_en    = RegWre | r_pend_en;
  assign w_wb_reg   = RegWre ? _thirdRg : r_pend_reg;
  assign w_wb_data  = RegWre ? _WBdata  : r_pend_data;
  assign w_rec      = pack_rec(_Pc0, _instruction, w_wb_en, w_wb_reg, w_wb_data);

  assign w_push_req = PCWre & enable;
  assign w_drop     = w_push_req & w_full;
  assign out_valid  = ~w_empty;
  assign w_hs       = out_valid & out_ready;
  assign w_pop      = w_hs & (r_state == W_DATA);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push_req),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= W_PC;
      r_pend_en   <= 1'b0;
      r_pend_reg  <= '0;
      r_pend_data <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (PCWre) begin
        r_pend_en   <= 1'b0;
        r_pend_reg  <= '0;
        r_pend_data <= '0;
      end else if (RegWre) begin
        r_pend_en   <= 1'b1;
        r_pend_reg  <= _thirdRg;
        r_pend_data <= _WBdata;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word      = '0;
    case (r_state)
      W_PC:    w_word = w_head[PC_LSB +: 32];
      W_INSTR: w_word = w_head[INSTR_LSB +: 32];
      W_REG:   w_word = {26'd0, w_head[WBEN_BIT], w_head[WBREG_LSB +: 5]};
      W_DATA:  w_word = w_head[WBDATA_LSB +: 32];
    endcase
    if (w_hs) begin
      case (r_state)
        W_PC:    w_state_nxt = W_INSTR;
        W_INSTR: w_state_nxt = W_REG;
        W_REG:   w_state_nxt = W_DATA;
        W_DATA:  w_state_nxt = W_PC;
      endcase
    end
  end

  // Gated so the stream reads as zero the instant reset empties the FIFO.
  assign out_data = out_valid ? w_word : '0;
  assign out_last = out_valid & (r_state == W_DATA);
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: directed scenarios plus random traffic,
// checked against a record-level reference model.
module tb_cpu_trace_capture;

  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          PCWre;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          RegWre;
  logic [4:0]    rg;
  logic [31:0]   wbd;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overflow;
  logic [DW-1:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Expected words still to be delivered: {last, data}
  logic [32:0] exp_q[$];
  int          m_occ;
  int          m_widx;
  logic        m_pend_en;
  logic [4:0]  m_pend_reg;
  logic [31:0] m_pend_data;
  logic        m_ovf;
  int          m_drop;
  logic [32:0] m_e;
  logic        m_hs;
  logic        m_pop;
  logic        r_en;
  logic [4:0]  r_rg;
  logic [31:0] r_d;

  always #5 clk = ~clk;

  cpu_trace_capture #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .PCWre        (PCWre),
    ._Pc0         (pc),
    ._instruction (instr),
    .RegWre       (RegWre),
    ._thirdRg     (rg),
    ._WBdata      (wbd),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: checks the state after the last edge, then
  // advances the model using the inputs that will be seen at the next edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_occ = 0; m_widx = 0;
      m_pend_en = 1'b0; m_pend_reg = '0; m_pend_data = '0;
      m_ovf = 1'b0; m_drop = 0;
    end else begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_occ > 0});
      chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          m_e = exp_q.pop_front();
          chk("word_data", 64'(out_data), 64'(m_e[31:0]));
          chk("word_last", {63'd0, out_last}, {63'd0, m_e[32]});
        end
      end
      m_hs  = (m_occ > 0) && out_ready;
      m_pop = m_hs && (m_widx == 3);
      if (m_hs) m_widx = (m_widx + 1) % 4;
      if (PCWre) begin
        if (enable) begin
          if (RegWre) begin r_en = 1'b1; r_rg = rg; r_d = wbd; end
          else begin r_en = m_pend_en; r_rg = m_pend_reg; r_d = m_pend_data; end
          if (m_occ == DEPTH) begin
            m_ovf = 1'b1;
            if (m_drop < (1 << DW) - 1) m_drop++;
          end else begin
            m_occ++;
            exp_q.push_back({1'b0, pc});
            exp_q.push_back({1'b0, instr});
            exp_q.push_back({1'b0, 26'd0, r_en, r_rg});
            exp_q.push_back({1'b1, r_d});
          end
        end
        m_pend_en = 1'b0; m_pend_reg = '0; m_pend_data = '0;
      end else if (RegWre) begin
        m_pend_en = 1'b1; m_pend_reg = rg; m_pend_data = wbd;
      end
      if (m_pop) m_occ--;
    end
  end

  task automatic drive(input logic en, input logic pcwe, input logic [31:0] p,
                       input logic [31:0] ins, input logic rw, input logic [4:0] r,
                       input logic [31:0] d, input logic rdy);
    enable = en; PCWre = pcwe; pc = p; instr = ins;
    RegWre = rw; rg = r; wbd = d; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0; PCWre = 1'b0; pc = '0; instr = '0;
    RegWre = 1'b0; rg = '0; wbd = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_overflow", {63'd0, overflow}, 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);

    // Pending writeback captured two cycles before the retire
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b1);
    idle(1'b1, 1);
    drive(1'b1, 1'b1, 32'h4, 32'h02108020, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b1, 6);

    // Retire with no writeback
    drive(1'b1, 1'b1, 32'h8, 32'hdeadbeef, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b1, 6);

    // Overflow: nine retires with the consumer stalled
    for (int i = 0; i < 9; i++)
      drive(1'b1, 1'b1, 32'h100 + 32'(i * 4), $urandom, 1'(i % 2), 5'(i), $urandom, 1'b0);
    idle(1'b0, 1);
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    idle(1'b1, 40);

    // Consumer toggling ready every cycle
    for (int i = 0; i < 24; i++)
      drive(1'b1, 1'(i % 3 == 0), $urandom, $urandom, 1'(i % 2), 5'($urandom), $urandom, 1'(i % 2));
    idle(1'b1, 40);

    // Reset arriving after the second word of a record
    drive(1'b1, 1'b1, 32'h200, 32'h11112222, 1'b1, 5'd9, 32'h99, 1'b0);
    idle(1'b1, 2);
    enable = 1'b1; PCWre = 1'b0; RegWre = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrec_valid", {63'd0, out_valid}, 64'd0);
    chk("midrec_last", {63'd0, out_last}, 64'd0);
    chk("midrec_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 1'b1, 32'h300, 32'h33334444, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b1, 6);

    // Random traffic with periodic consumer stalls to force drops
    for (int i = 0; i < 1500; i++)
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) == 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            (i % 250 < 70) ? 1'b0 : 1'($urandom_range(0, 3) != 0));
    idle(1'b1, 80);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
